// File: rtl/if_prefetch_stage_pkg.sv
// Shared CPU front-end definitions: NOP encoding, redirect priority, fetch-queue payload.
package if_prefetch_stage_pkg;

    localparam int unsigned PC_W    = 30;
    localparam int unsigned INST_W  = 32;
    localparam int unsigned FETCH_W = PC_W + INST_W;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        REDIR_NONE  = 3'd0,
        REDIR_START = 3'd1,
        REDIR_TRAP  = 3'd2,
        REDIR_RET   = 3'd3,
        REDIR_JMP   = 3'd4
    } redir_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Fixed priority: pc_start > trap > ret > jmp.
    function automatic redir_e redir_pick(input logic start, input logic trap,
                                          input logic ret, input logic jmp);
        if (start)     return REDIR_START;
        else if (trap) return REDIR_TRAP;
        else if (ret)  return REDIR_RET;
        else if (jmp)  return REDIR_JMP;
        else           return REDIR_NONE;
    endfunction

endpackage

// File: rtl/if_prefetch_stage_if.sv
// IF -> ID handshake: head instruction/PC offered with valid, consumed on ready.
interface if_prefetch_stage_if;
    import if_prefetch_stage_pkg::*;

    logic              id_valid;
    logic              id_ready;
    logic [INST_W-1:0] inst_id;
    logic [PC_W-1:0]   pc_id;

    modport master (output id_valid, inst_id, pc_id, input id_ready);
    modport slave  (input id_valid, inst_id, pc_id, output id_ready);

endinterface

// File: rtl/if_prefetch_stage_fetch_fifo.sv
// Power-of-two FIFO with flush; push is accepted when full if a pop happens in the same cycle.
module fetch_fifo #(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned DWIDTH = 62
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  logic [DWIDTH-1:0]            i_wdata,
    output logic [DWIDTH-1:0]            o_rdata,
    output logic [$clog2(QDEPTH):0]      o_count
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DWIDTH-1:0] r_mem [QDEPTH];
    logic [PW-1:0]     r_rd;
    logic [PW-1:0]     r_wr;
    logic [CW-1:0]     r_count;
    logic              w_do_pop;
    logic              w_do_push;

    assign w_do_pop  = i_pop & (r_count != '0);
    assign w_do_push = i_push & ((r_count != CW'(QDEPTH)) | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + PW'(1);
            if (w_do_pop)  r_rd <= r_rd + PW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction prefetch: PC/redirect control, single-cycle RAM fetch, and a fetch queue toward ID.
module if_prefetch_stage
    import if_prefetch_stage_pkg::*;
#(
    parameter int unsigned       IWIDTH   = 14,
    parameter int unsigned       QDEPTH   = 4,
    parameter logic [PC_W-1:0]   RESET_PC = 30'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pc_start,
    input  logic [PC_W-1:0]      start_adr,
    input  logic                 redir_trap,
    input  logic [PC_W-1:0]      trap_adr,
    input  logic                 redir_ret,
    input  logic [PC_W-1:0]      ret_adr,
    input  logic                 redir_jmp,
    input  logic [PC_W-1:0]      jmp_adr,
    if_prefetch_stage_if.master  id_bus,
    output logic                 post_redir,
    output logic [IWIDTH-1:0]    iram_radr,
    input  logic [INST_W-1:0]    iram_rdata,
    input  logic                 mon_sel,
    input  logic [IWIDTH-1:0]    mon_radr,
    output logic [INST_W-1:0]    mon_rdata,
    output logic [31:0]          pc_data
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_inflight_pc;
    logic               r_inflight;
    logic               r_post_redir;
    logic               r_trap_sup;

    redir_e             w_sel;
    logic               w_flush;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [CW:0]        w_load;
    logic [CW-1:0]      w_count;
    logic [FETCH_W-1:0] w_fifo_rdata;
    fetch_entry_t       w_head;
    fetch_entry_t       w_wentry;

    // ret/jmp are ignored the cycle after a taken trap; trap itself always wins.
    assign w_sel   = redir_pick(pc_start, redir_trap,
                                redir_ret & ~r_trap_sup, redir_jmp & ~r_trap_sup);
    assign w_flush = (w_sel != REDIR_NONE);

    assign w_load  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue = ~mon_sel & ~w_flush & (w_load < (CW+1)'(QDEPTH));
    assign w_push  = r_inflight & ~w_flush;
    assign w_pop   = id_bus.id_valid & id_bus.id_ready & ~w_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_post_redir  <= 1'b0;
            r_trap_sup    <= 1'b0;
        end else begin
            unique case (w_sel)
                REDIR_START: r_pc <= start_adr;
                REDIR_TRAP:  r_pc <= trap_adr;
                REDIR_RET:   r_pc <= ret_adr;
                REDIR_JMP:   r_pc <= jmp_adr;
                default:     if (w_issue) r_pc <= r_pc + PC_W'(1);
            endcase
            r_inflight    <= w_issue;
            r_inflight_pc <= r_pc;
            r_post_redir  <= (w_sel == REDIR_TRAP) | (w_sel == REDIR_RET) | (w_sel == REDIR_JMP);
            r_trap_sup    <= (w_sel == REDIR_TRAP);
        end
    end

    assign w_wentry = '{pc: r_inflight_pc, inst: iram_rdata};

    fetch_fifo #(
        .QDEPTH (QDEPTH),
        .DWIDTH (FETCH_W)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (w_wentry),
        .o_rdata (w_fifo_rdata),
        .o_count (w_count)
    );

    assign w_head          = fetch_entry_t'(w_fifo_rdata);
    assign id_bus.id_valid = (w_count != '0);
    assign id_bus.inst_id  = id_bus.id_valid ? w_head.inst : NOP_INST;
    assign id_bus.pc_id    = id_bus.id_valid ? w_head.pc   : '0;

    assign iram_radr  = mon_sel ? mon_radr : r_pc[IWIDTH-1:0];
    assign mon_rdata  = iram_rdata;
    assign pc_data    = {r_pc, 2'b00};
    assign post_redir = r_post_redir;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: RAM word n holds 0x100+n, expectations hand-computed.
module tb_if_prefetch_stage;
    import if_prefetch_stage_pkg::*;

    localparam int unsigned IWIDTH = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pc_start, redir_trap, redir_ret, redir_jmp, mon_sel;
    logic [29:0]       start_adr, trap_adr, ret_adr, jmp_adr;
    logic              post_redir;
    logic [IWIDTH-1:0] iram_radr, mon_radr;
    logic [31:0]       iram_rdata, mon_rdata, pc_data;
    logic [31:0]       ram [0:(1<<IWIDTH)-1];

    int n_checks = 0;
    int n_errors = 0;

    if_prefetch_stage_if id_bus ();

    if_prefetch_stage #(.IWIDTH(IWIDTH), .QDEPTH(4), .RESET_PC(30'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_start   (pc_start),
        .start_adr  (start_adr),
        .redir_trap (redir_trap),
        .trap_adr   (trap_adr),
        .redir_ret  (redir_ret),
        .ret_adr    (ret_adr),
        .redir_jmp  (redir_jmp),
        .jmp_adr    (jmp_adr),
        .id_bus     (id_bus),
        .post_redir (post_redir),
        .iram_radr  (iram_radr),
        .iram_rdata (iram_rdata),
        .mon_sel    (mon_sel),
        .mon_radr   (mon_radr),
        .mon_rdata  (mon_rdata),
        .pc_data    (pc_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) iram_rdata <= ram[iram_radr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [29:0] pc);
        chk({tag, ".valid"}, 64'(id_bus.id_valid), 64'd1);
        chk({tag, ".pc"},    64'(id_bus.pc_id),    64'(pc));
        chk({tag, ".inst"},  64'(id_bus.inst_id),  64'(32'h100 + 32'(pc)));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, 64'(id_bus.id_valid), 64'd0);
        chk({tag, ".inst"},  64'(id_bus.inst_id),  64'(NOP_INST));
        chk({tag, ".pc"},    64'(id_bus.pc_id),    64'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << IWIDTH); i++) ram[i] = 32'h100 + 32'(i);
        rst_n = 1'b0; pc_start = 1'b0; redir_trap = 1'b0; redir_ret = 1'b0; redir_jmp = 1'b0;
        mon_sel = 1'b0; start_adr = '0; trap_adr = '0; ret_adr = '0; jmp_adr = '0; mon_radr = '0;
        id_bus.id_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk_empty("rst");
        chk("rst.post_redir", 64'(post_redir), 64'd0);
        chk("rst.pc_data", 64'(pc_data), 64'd0);
        chk("rst.radr", 64'(iram_radr), 64'd0);

        // Streaming from reset: first valid two cycles after release
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot.c1.valid", 64'(id_bus.id_valid), 64'd0);
        chk("boot.c1.radr", 64'(iram_radr), 64'd1);
        @(negedge clk);
        chk_head("boot.c2", 30'd0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk_head($sformatf("stream%0d", k), 30'(k));
        end

        // Backpressure: queue fills with 7..10, fetch address freezes at 11
        id_bus.id_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk_head("stall", 30'd7);
        chk("stall.radr", 64'(iram_radr), 64'd11);
        chk("stall.pc_data", 64'(pc_data), 64'd44);
        id_bus.id_ready = 1'b1;
        for (int k = 8; k <= 13; k++) begin
            @(negedge clk);
            chk_head($sformatf("drain%0d", k), 30'(k));
        end

        // Jump with three queued and one in flight
        id_bus.id_ready = 1'b0;
        @(negedge clk);
        chk_head("prejmp", 30'd13);
        redir_jmp = 1'b1; jmp_adr = 30'h40;
        @(negedge clk);
        chk_empty("jmp.flush");
        chk("jmp.post_redir", 64'(post_redir), 64'd1);
        chk("jmp.radr", 64'(iram_radr), 64'h40);
        redir_jmp = 1'b0; id_bus.id_ready = 1'b1;
        @(negedge clk);
        chk("jmp.c1.valid", 64'(id_bus.id_valid), 64'd0);
        chk("jmp.c1.post_redir", 64'(post_redir), 64'd0);
        @(negedge clk);
        chk_head("jmp.first", 30'h40);
        @(negedge clk);
        chk_head("jmp.second", 30'h41);

        // Trap then jump next cycle: jump is suppressed
        redir_trap = 1'b1; trap_adr = 30'h80;
        @(negedge clk);
        chk("trap.radr", 64'(iram_radr), 64'h80);
        redir_trap = 1'b0; redir_jmp = 1'b1; jmp_adr = 30'h20;
        @(negedge clk);
        chk("trapsup.radr", 64'(iram_radr), 64'h81);
        chk("trapsup.post_redir", 64'(post_redir), 64'd0);
        redir_jmp = 1'b0;
        @(negedge clk);
        chk_head("trap.first", 30'h80);

        // Trap and jump together: trap wins
        redir_trap = 1'b1; redir_jmp = 1'b1;
        @(negedge clk);
        chk("trapjmp.radr", 64'(iram_radr), 64'h80);
        redir_trap = 1'b0; redir_jmp = 1'b0;
        repeat (2) @(negedge clk);
        chk_head("trapjmp.first", 30'h80);

        // Ret beats jmp; pc_start beats trap
        redir_ret = 1'b1; ret_adr = 30'h30; redir_jmp = 1'b1;
        @(negedge clk);
        chk("retjmp.radr", 64'(iram_radr), 64'h30);
        chk("retjmp.post_redir", 64'(post_redir), 64'd1);
        redir_ret = 1'b0; redir_jmp = 1'b0;
        pc_start = 1'b1; start_adr = 30'h10; redir_trap = 1'b1;
        @(negedge clk);
        chk("start.radr", 64'(iram_radr), 64'h10);
        pc_start = 1'b0; redir_trap = 1'b0;
        repeat (2) @(negedge clk);
        chk_head("start.first", 30'h10);
        @(negedge clk);
        chk_head("start.second", 30'h11);

        // Monitor owns the RAM port; in-flight fetch 0x12 still lands
        mon_sel = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mon_radr = IWIDTH'(5 + k);
            @(negedge clk);
            chk($sformatf("mon%0d.rdata", k), 64'(mon_rdata), 64'(32'h105 + 32'(k)));
            chk($sformatf("mon%0d.radr", k), 64'(iram_radr), 64'(5 + k));
            if (k == 0) chk_head("mon.inflight", 30'h12);
            else        chk($sformatf("mon%0d.valid", k), 64'(id_bus.id_valid), 64'd0);
        end
        chk("mon.pc_hold", 64'(pc_data), 64'(32'h13 << 2));
        mon_sel = 1'b0;
        @(negedge clk);
        chk("mon.resume.valid", 64'(id_bus.id_valid), 64'd0);
        chk("mon.resume.radr", 64'(iram_radr), 64'h14);
        @(negedge clk);
        chk_head("mon.resume", 30'h13);

        // Reset mid-operation discards everything
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_empty("midrst");
        chk("midrst.pc_data", 64'(pc_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.c1.valid", 64'(id_bus.id_valid), 64'd0);
        @(negedge clk);
        chk_head("midrst.first", 30'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_prefetch_stage.md
IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- IWIDTH, 14, instruction RAM word-address width; RAM address = pc[IWIDTH+1:2].
- QDEPTH, 4, fetch-queue entries; power of two, 2..16.
- RESET_PC, 30'd0, pc_if value after reset.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_start  in  1  load start_adr into pc_if.
- start_adr  in  30  start word address [31:2].
- redir_trap  in  1  interrupt/ecall/exception redirect.
- trap_adr  in  30  mtvec target.
- redir_ret  in  1  mret/sret/uret redirect.
- ret_adr  in  30  mepc/sepc target.
- redir_jmp  in  1  branch/jump taken.
- jmp_adr  in  30  branch/jump target.
- id_ready  in  1  ID accepts the head instruction.
- id_valid  out  1  inst_id/pc_id valid.
- inst_id  out  32  head instruction.
- pc_id  out  30  head PC.
- post_redir  out  1  registered: any redirect was taken last cycle.
- iram_radr  out  IWIDTH  RAM read address.
- iram_rdata  in  32  RAM data, one cycle after address.
- mon_sel  in  1  monitor owns the RAM read port.
- mon_radr  in  IWIDTH  monitor read address.
- mon_rdata  out  32  equals iram_rdata.
- pc_data  out  32  {pc_if, 2'b00}.

Function
REQ-003 iram_radr SHALL be mon_radr when mon_sel=1, otherwise pc_if[IWIDTH+1:2].
REQ-004 A fetch SHALL issue in a cycle iff mon_sel=0, no redirect or pc_start is taken, and (occupancy + in-flight) < QDEPTH; on issue pc_if increments by 1, wrapping 30'h3FFFFFFF to 0.
REQ-005 An issued fetch SHALL return one cycle later and be pushed into the queue tail with its PC, unless it was killed (REQ-008).
REQ-006 Redirect priority: pc_start > redir_trap > redir_ret > redir_jmp; the winner's address SHALL load pc_if on the next edge.
REQ-007 redir_ret and redir_jmp SHALL be ignored in the cycle after a taken redir_trap; redir_trap SHALL never be suppressed.
REQ-008 A taken redirect or pc_start SHALL flush the queue (occupancy = 0) and kill the in-flight fetch; a pop in the same cycle has no further effect.
REQ-009 id_valid SHALL equal (occupancy != 0); pop occurs on id_valid & id_ready; inst_id/pc_id SHALL be the head entry, or 32'h00000013 and 0 when empty.
REQ-010 Full queue with pop and returning fetch in the same cycle: both SHALL occur, occupancy unchanged, no entry lost.
REQ-011 Queue pointers SHALL be log2(QDEPTH) bits, wrapping modulo QDEPTH; occupancy SHALL be log2(QDEPTH)+1 bits and never exceed QDEPTH.
REQ-012 mon_sel=1 with a fetch in flight: the returning fetch SHALL still be pushed; no new fetch issues until mon_sel=0.
REQ-013 Steady state with id_ready=1 and no redirects: one instruction per cycle; first id_valid two cycles after reset release.

Reset
REQ-014 On rst_n low: pc_if = RESET_PC, occupancy = 0, in-flight = 0, post_redir = 0, trap-suppress flag = 0, id_valid = 0, inst_id = 32'h00000013, pc_id = 0.
REQ-015 Reset mid-operation SHALL discard all queued and in-flight fetches; queue storage contents need no reset.

Structure
REQ-016 The shared CPU package SHALL hold the NOP constant 32'h00000013 and the redirect-priority encoding.
REQ-017 The queue SHALL be a sub-module fetch_fifo (parameters QDEPTH and data width 62 = PC + instruction) with push, pop, flush, count.

Verification
REQ-018 Reset release, RAM words 0..7 = 0x100+n, id_ready=1 -> from cycle 2, pc_id 0,1,2,... with inst 0x100,0x101,... every cycle.
REQ-019 id_ready=0 for 10 cycles -> occupancy saturates at 4, iram_radr frozen, no fetch lost; id_ready=1 -> in-order drain.
REQ-020 redir_jmp to 0x40 with 3 queued -> next cycle id_valid=0; in-flight discarded; next valid pc_id = 0x40.
REQ-021 redir_trap (0x80) then redir_jmp (0x20) next cycle -> jmp ignored, stream starts at 0x80; trap+jmp same cycle -> 0x80.
REQ-022 Full queue, pop and fetch return in the same cycle -> occupancy stays 4, order preserved; mon_sel=1 for 5 cycles -> mon_rdata = RAM[mon_radr], no new fetches, resume at correct PC.
